// File: rtl/ff_bank_ego1_pkg.sv
// ff_bank_pkg: shared definitions for the ff_bank_ego1 flip-flop bank.
//   - mode_e   : per-cycle flip-flop behaviour (SR / JK / D / T)
//   - sr_pol_e : resolution of S=R=1 in SR mode
//   - next_q() : single-bit next-state decode shared by every channel
package ff_bank_pkg;

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    POL_HOLD  = 2'd0,
    POL_SET   = 2'd1,
    POL_RESET = 2'd2
  } sr_pol_e;

  // Next state of one bit. The b input is ignored in D and T modes.
  // An undefined policy code (3) falls through to hold.
  function automatic logic next_q(input logic [1:0] mode,
                                  input logic       a,
                                  input logic       b,
                                  input logic       q,
                                  input logic [1:0] policy);
    logic nq;
    nq = q;
    case (mode)
      MODE_SR: begin
        case ({a, b})
          2'b10:   nq = 1'b1;
          2'b01:   nq = 1'b0;
          2'b11: begin
            case (policy)
              POL_SET:   nq = 1'b1;
              POL_RESET: nq = 1'b0;
              default:   nq = q;
            endcase
          end
          default: nq = q;
        endcase
      end
      MODE_JK: begin
        case ({a, b})
          2'b10:   nq = 1'b1;
          2'b01:   nq = 1'b0;
          2'b11:   nq = ~q;
          default: nq = q;
        endcase
      end
      MODE_D:  nq = a;
      default: nq = q ^ a;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/ff_bank_ego1_if.sv
// ff_bank_ego1_if: control/data bundle of the flip-flop bank.
//   master : drives mode, en, a, b, clr_flags; observes q, qn, err_sr, chg_cnt
//   slave  : the bank itself
interface ff_bank_ego1_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic [1:0]       mode;
  logic             en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             clr_flags;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic [WIDTH-1:0] err_sr;
  logic [CNT_W-1:0] chg_cnt;

  modport master (
    output mode, en, a, b, clr_flags,
    input  q, qn, err_sr, chg_cnt
  );

  modport slave (
    input  mode, en, a, b, clr_flags,
    output q, qn, err_sr, chg_cnt
  );
endinterface

// File: rtl/ff_bank_ego1_cell.sv
// ff_cell: one storage channel of the bank.
//   clk, rst_n     : clock, synchronous active-low reset
//   mode_i, en_i   : behaviour select and clock enable
//   a_i, b_i       : S/J/D/T and R/K inputs
//   clr_flags_i    : clears the sticky error bit
//   q_o            : stored bit
//   q_nxt_o        : value q will take at the next edge (for change detect)
//   err_o          : sticky S=R=1 flag
module ff_cell
  import ff_bank_pkg::*;
#(
  parameter logic [1:0] SR_POLICY = POL_HOLD,
  parameter logic       RST_BIT   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode_i,
  input  logic       en_i,
  input  logic       a_i,
  input  logic       b_i,
  input  logic       clr_flags_i,
  output logic       q_o,
  output logic       q_nxt_o,
  output logic       err_o
);

  logic q_q, q_d;
  logic err_q, err_d;
  logic sr_conflict;

  always_comb begin
    q_d         = q_q;
    err_d       = err_q;
    sr_conflict = en_i && (mode_i == MODE_SR) && a_i && b_i;
    if (en_i) begin
      q_d = next_q(mode_i, a_i, b_i, q_q, SR_POLICY);
    end
    // A fresh conflict beats a simultaneous clear so no event is lost.
    if (sr_conflict) begin
      err_d = 1'b1;
    end else if (clr_flags_i) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q   <= RST_BIT;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      err_q <= err_d;
    end
  end

  assign q_o     = q_q;
  assign q_nxt_o = q_d;
  assign err_o   = err_q;

endmodule

// File: rtl/ff_bank_ego1.sv
// ff_bank_ego1: WIDTH-channel clocked flip-flop bank, selectable SR/JK/D/T,
// with sticky S=R=1 error flags and a saturating change counter.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of ff_bank_ego1_if
//                (mode, en, a, b, clr_flags in; q, qn, err_sr, chg_cnt out)
module ff_bank_ego1
  import ff_bank_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               CNT_W     = 8,
  parameter int               SR_POLICY = 0,
  parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
  input  logic clk,
  input  logic rst_n,
  ff_bank_ego1_if.slave bus
);

  localparam logic [1:0]       POLICY  = SR_POLICY[1:0];
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] q_w;
  logic [WIDTH-1:0] q_nxt_w;
  logic [WIDTH-1:0] err_w;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             changed;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell #(
      .SR_POLICY (POLICY),
      .RST_BIT   (RST_VAL[i])
    ) u_cell (
      .clk         (clk),
      .rst_n       (rst_n),
      .mode_i      (bus.mode),
      .en_i        (bus.en),
      .a_i         (bus.a[i]),
      .b_i         (bus.b[i]),
      .clr_flags_i (bus.clr_flags),
      .q_o         (q_w[i]),
      .q_nxt_o     (q_nxt_w[i]),
      .err_o       (err_w[i])
    );
  end

  // q_nxt_w already equals q_w when en=0; the en term keeps intent explicit.
  assign changed = bus.en && (q_nxt_w != q_w);

  always_comb begin
    cnt_d = cnt_q;
    if (bus.clr_flags) begin
      cnt_d = '0;
    end else if (changed && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.q       = q_w;
  assign bus.qn      = ~q_w;
  assign bus.err_sr  = err_w;
  assign bus.chg_cnt = cnt_q;

endmodule

// File: tb/tb_ff_bank_ego1.sv
module tb_ff_bank_ego1;
  import ff_bank_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ff_bank_ego1_if #(.WIDTH(8), .CNT_W(3)) if0 ();
  ff_bank_ego1_if #(.WIDTH(8), .CNT_W(8)) if1 ();
  ff_bank_ego1_if #(.WIDTH(8), .CNT_W(8)) if2 ();

  // Main DUT: hold policy, 3-bit counter so saturation is reachable.
  ff_bank_ego1 #(.WIDTH(8), .CNT_W(3), .SR_POLICY(0), .RST_VAL(8'hA5))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  ff_bank_ego1 #(.WIDTH(8), .CNT_W(8), .SR_POLICY(1), .RST_VAL(8'hA5))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  ff_bank_ego1 #(.WIDTH(8), .CNT_W(8), .SR_POLICY(2), .RST_VAL(8'hA5))
    u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  typedef struct {
    logic       rst_n;
    logic [1:0] mode;
    logic       en;
    logic [7:0] a;
    logic [7:0] b;
    logic       clr;
    logic [7:0] q;
    logic [7:0] err;
    logic [2:0] cnt;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] q;
    logic [7:0] err;
    logic [2:0] cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input logic r, input logic [1:0] m, input logic e,
                     input logic [7:0] va, input logic [7:0] vb, input logic c,
                     input logic [7:0] eq, input logic [7:0] ee, input logic [2:0] ec);
    vec_t v;
    v.rst_n = r; v.mode = m; v.en = e; v.a = va; v.b = vb; v.clr = c;
    v.q = eq; v.err = ee; v.cnt = ec;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [1:0] m, input logic e,
                       input logic [7:0] va, input logic [7:0] vb, input logic c);
    rst_n = r;
    if0.mode = m; if0.en = e; if0.a = va; if0.b = vb; if0.clr_flags = c;
    if1.mode = m; if1.en = e; if1.a = va; if1.b = vb; if1.clr_flags = c;
    if2.mode = m; if2.en = e; if2.a = va; if2.b = vb; if2.clr_flags = c;
  endtask

  task automatic chk8(input string name, input int idx,
                      input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, req);
    end
  endtask

  initial begin
    exp_t e;
    int   n;

    // Reset with random data, en=1; reset must dominate.
    add(0, MODE_SR, 1, 8'($urandom), 8'($urandom), 0, 8'hA5, 8'h00, 3'd0);
    add(0, MODE_SR, 1, 8'hFF, 8'hFF, 0, 8'hA5, 8'h00, 3'd0);
    // Clear q via D, then SR sequence.
    add(1, MODE_D,  1, 8'h00, 8'h00, 0, 8'h00, 8'h00, 3'd1);
    add(1, MODE_SR, 1, 8'h0F, 8'h00, 0, 8'h0F, 8'h00, 3'd2);
    add(1, MODE_SR, 1, 8'h03, 8'h03, 0, 8'h0F, 8'h03, 3'd2);
    add(1, MODE_SR, 1, 8'h00, 8'h00, 1, 8'h0F, 8'h00, 3'd0);
    add(1, MODE_SR, 1, 8'h30, 8'h30, 1, 8'h0F, 8'h30, 3'd0);  // set beats clear
    add(1, MODE_SR, 1, 8'h00, 8'h0F, 1, 8'h00, 8'h00, 3'd0);  // clear beats count
    // JK toggle
    add(1, MODE_JK, 1, 8'hFF, 8'hFF, 0, 8'hFF, 8'h00, 3'd1);
    add(1, MODE_JK, 1, 8'hFF, 8'hFF, 0, 8'h00, 8'h00, 3'd2);
    add(1, MODE_JK, 1, 8'hFF, 8'hFF, 0, 8'hFF, 8'h00, 3'd3);
    // D / T with enable gating
    add(1, MODE_D,  1, 8'h3C, 8'h00, 0, 8'h3C, 8'h00, 3'd4);
    add(1, MODE_SR, 1, 8'h80, 8'h80, 0, 8'h3C, 8'h80, 3'd4);
    add(1, MODE_D,  0, 8'hFF, 8'h00, 0, 8'h3C, 8'h80, 3'd4);
    add(1, MODE_D,  0, 8'hFF, 8'h00, 1, 8'h3C, 8'h00, 3'd0);  // clr acts with en=0
    add(1, MODE_T,  1, 8'h01, 8'h00, 0, 8'h3D, 8'h00, 3'd1);
    // Saturation of the 3-bit counter
    for (int k = 1; k <= 10; k++) begin
      n = (1 + k > 7) ? 7 : 1 + k;
      add(1, MODE_T, 1, 8'h01, 8'h00, 0, (k % 2 == 1) ? 8'h3C : 8'h3D, 8'h00, 3'(n));
    end
    add(1, MODE_T,  1, 8'h01, 8'h00, 1, 8'h3C, 8'h00, 3'd0);
    add(1, MODE_T,  1, 8'h00, 8'h00, 0, 8'h3C, 8'h00, 3'd0);
    add(1, MODE_JK, 1, 8'hC0, 8'h03, 0, 8'hFC, 8'h00, 3'd1);
    add(1, MODE_JK, 1, 8'h00, 8'h0C, 0, 8'hF0, 8'h00, 3'd2);
    // Reset during JK toggling
    add(1, MODE_D,  1, 8'hFF, 8'h00, 0, 8'hFF, 8'h00, 3'd3);
    add(1, MODE_JK, 1, 8'hFF, 8'hFF, 0, 8'h00, 8'h00, 3'd4);
    add(1, MODE_JK, 1, 8'hFF, 8'hFF, 0, 8'hFF, 8'h00, 3'd5);
    add(0, MODE_JK, 1, 8'hFF, 8'hFF, 0, 8'hA5, 8'h00, 3'd0);
    add(0, MODE_JK, 1, 8'hFF, 8'hFF, 1, 8'hA5, 8'h00, 3'd0);
    add(1, MODE_SR, 1, 8'hFF, 8'hFF, 0, 8'hA5, 8'hFF, 3'd0);
    add(0, MODE_SR, 1, 8'hFF, 8'hFF, 0, 8'hA5, 8'h00, 3'd0);
    add(1, MODE_SR, 0, 8'hFF, 8'hFF, 0, 8'hA5, 8'h00, 3'd0);  // no flag when disabled

    drive(0, MODE_SR, 0, 8'h00, 8'h00, 0);
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].mode, vecs[i].en, vecs[i].a, vecs[i].b, vecs[i].clr);
      e.idx = i; e.q = vecs[i].q; e.err = vecs[i].err; e.cnt = vecs[i].cnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty vec=%0d", i);
      end else begin
        e = sb.pop_front();
        chk8("q",       e.idx, if0.q,                e.q);
        chk8("qn",      e.idx, if0.qn,               ~e.q);
        chk8("err_sr",  e.idx, if0.err_sr,           e.err);
        chk8("chg_cnt", e.idx, {5'd0, if0.chg_cnt},  {5'd0, e.cnt});
      end
    end

    // SR_POLICY comparison across the three banks.
    drive(0, MODE_SR, 1, 8'h00, 8'h00, 0);
    @(posedge clk); #1;
    drive(1, MODE_SR, 1, 8'hF0, 8'h0F, 0);
    @(posedge clk); #1;
    chk8("pol_q_hold_1",  100, if0.q, 8'hF0);
    chk8("pol_q_set_1",   100, if1.q, 8'hF0);
    chk8("pol_q_reset_1", 100, if2.q, 8'hF0);
    drive(1, MODE_SR, 1, 8'h3C, 8'h3C, 0);
    @(posedge clk); #1;
    chk8("pol_q_hold",    101, if0.q, 8'hF0);
    chk8("pol_q_set",     101, if1.q, 8'hFC);
    chk8("pol_q_reset",   101, if2.q, 8'hC0);
    chk8("pol_err_set",   101, if1.err_sr, 8'h3C);
    chk8("pol_cnt_hold",  101, {5'd0, if0.chg_cnt}, 8'd1);
    chk8("pol_cnt_set",   101, if1.chg_cnt, 8'd2);
    chk8("pol_qn_reset",  101, if2.qn, 8'h3F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ff_bank_ego1.md
Name: ff_bank_ego1

Overview:
- Parametrised, clocked successor to the gate-level RS latch used in the EGO1 labs.
- Provides WIDTH independent storage bits sharing one clock, runtime-selectable as SR, JK, D or T flip-flops.
- Adds forbidden-input handling with a sticky error flag and a saturating change counter.
- Sits between debounced board switches/buttons and the LED/7-seg display logic.

Parameters:
- WIDTH, 8, number of flip-flop channels.
- CNT_W, 8, width of the change counter.
- SR_POLICY, 0, action on S=R=1 in SR mode: 0 hold, 1 set-dominant, 2 reset-dominant.
- RST_VAL, 0 (WIDTH bits), value loaded into q on reset.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  synchronous active-low reset.
- mode  input  2  00 SR, 01 JK, 10 D, 11 T; sampled every cycle.
- en  input  1  clock enable; 0 = all channels hold.
- a  input  WIDTH  per channel S / J / D / T input.
- b  input  WIDTH  per channel R / K input; ignored in D and T modes.
- clr_flags  input  1  clears err_sr and chg_cnt.
- q  output  WIDTH  stored state.
- qn  output  WIDTH  always ~q; combinational from q, never a separate register.
- err_sr  output  WIDTH  sticky per-channel flag, set when S=R=1 is seen in SR mode while en=1.
- chg_cnt  output  CNT_W  saturating count of enabled cycles in which any q bit changed.

Behaviour:
- Reset: rst_n=0 at a rising edge gives q=RST_VAL, qn=~RST_VAL, err_sr=0, chg_cnt=0. Reset wins over every other input, including mid-operation and with en=1.
- Latency: q updates one cycle after inputs are sampled. No combinational path from a/b to q.
- en=0: q, err_sr and chg_cnt all hold. clr_flags still acts.
- SR mode, per bit:
  - (S,R)=00: hold.
  - 10: q=1.
  - 01: q=0.
  - 11: SR_POLICY result, and err_sr[i] is set.
- JK mode, per bit:
  - 00: hold.
  - 10: q=1.
  - 01: q=0.
  - 11: q=~q. Not an error.
- D mode: q=a.
- T mode: q = q ^ a.
- Mode changes take effect in the same cycle they are sampled. No pipeline flush is needed.
- err_sr: each bit stays 1 until clr_flags=1 or reset.
  - If clr_flags and a new S=R=1 event occur in the same cycle, the set wins, so err_sr[i]=1 afterwards.
- chg_cnt increments by 1 when en=1 and next q != q.
  - Saturates at 2^CNT_W-1; no wrap-around.
  - clr_flags in the same cycle as a change gives chg_cnt=0 (clear wins).
- Illegal SR_POLICY values (3) behave as 0 (hold).

Decomposition:
- Package ff_bank_pkg:
  - mode encoding constants MODE_SR/JK/D/T.
  - SR policy constants POL_HOLD/SET/RESET.
  - Shared next-state function next_q(mode, a, b, q, policy).
- Sub-module ff_cell:
  - One channel: registers q and err_sr, with the next-state decode.
  - Instantiated WIDTH times with a generate loop.
  - Change detect and chg_cnt stay in the top level.

Test Plan:
- Reset with RST_VAL=8'hA5: hold rst_n=0 for 2 cycles with random a/b/en=1 -> q=8'hA5, qn=8'h5A, err_sr=0, chg_cnt=0; then release.
- SR, SR_POLICY=0, en=1:
  - a=8'h0F, b=0 -> q=8'h0F.
  - Then a=8'h03, b=8'h03 -> q holds 8'h0F and err_sr=8'h03.
  - Then clr_flags=1 -> err_sr=0.
- JK toggle: q=8'h00, mode=01, a=b=8'hFF for 3 cycles -> q = FF, 00, FF; chg_cnt=3; err_sr stays 0.
- D and T with en gating:
  - mode=10, a=8'h3C -> q=8'h3C.
  - en=0 with a=8'hFF -> q stays 8'h3C.
  - mode=11, en=1, a=8'h01 -> q=8'h3D.
- Counter saturation, CNT_W=3: toggle in T mode with a=1 for 10 cycles -> chg_cnt stops at 7. clr_flags in the cycle of a change -> chg_cnt=0.
- Reset mid-operation: pull rst_n low during JK toggling at q=8'hFF -> next edge q=RST_VAL, and chg_cnt=0 regardless of clr_flags.
